i2s_transmitter: RTL
====================

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 12, meaning clk_in cycles per BCLK half-period (legal 2..255).
REQ-002 SHALL have clk_in, input, 1, 100 MHz system clock; the only clock; all logic on its rising edge.
REQ-003 SHALL have rst_in, input, 1, synchronous active-low reset (0 = reset, sampled on clk_in rising edge).
REQ-004 SHALL have left_sample_in, input, 16, signed left-channel sample.
REQ-005 SHALL have right_sample_in, input, 16, signed right-channel sample.
REQ-006 SHALL have new_sample_in, input, 1, one-cycle strobe that qualifies the left and right samples.
REQ-007 SHALL have i2s_bclk_out, output, 1, bit clock, master-generated.
REQ-008 SHALL have i2s_lrclk_out, output, 1, word select: 0 = left, 1 = right; period is 64 BCLK.
REQ-009 SHALL have i2s_data_out, output, 1, serial data, MSB first.
REQ-010 SHALL have frame_pulse_out, output, 1, one-cycle pulse when the holding register is loaded into the shifter.
REQ-011 SHALL have underrun_out, output, 1, one-cycle pulse at a frame load when no new pair is pending.
REQ-012 SHALL have overrun_out, output, 1, one-cycle pulse when a pending pair is overwritten before being consumed.

Function
REQ-013 SHALL implement a divider counter, 0..BCLK_HALF-1; at terminal count it wraps to 0 and toggles BCLK; BCLK period = 2*BCLK_HALF cycles (24 cycles by default, ~4.17 MHz).
REQ-014 SHALL define a "falling event" as a cycle in which BCLK toggles 1->0; all LRCLK and data changes occur only at falling events.
REQ-015 SHALL keep a 6-bit bit counter k that increments modulo 64 at each falling event.
REQ-016 SHALL drive LRCLK = k[5] after each falling event.
REQ-017 SHALL drive data, after each falling event, with a one-BCLK I2S delay: k = 1..16 outputs left[16-k]; k = 33..48 outputs right[48-k]; all other k output 0.
REQ-018 SHALL capture left/right into a holding register and set pending = 1 in the cycle after new_sample_in = 1.
REQ-019 SHALL pulse overrun_out for one cycle when new_sample_in = 1 and pending = 1 and no frame load occurs in that cycle; the new pair overwrites the old one.
REQ-020 SHALL perform a frame load at the falling event where k wraps 63->0: copy holding into the shift registers, clear pending, and pulse frame_pulse_out in the same cycle.
REQ-021 SHALL, if pending = 0 at a frame load, reload the last holding contents (repeat the previous pair) and pulse underrun_out.
REQ-022 SHALL, when new_sample_in coincides with a frame load, load the old holding pair, store the new pair, leave pending = 1, and assert neither overrun_out nor underrun_out.
REQ-023 SHALL keep the shift registers stable for the whole 64-bit frame regardless of new_sample_in.

Reset
REQ-024 SHALL set the following while rst_in = 0: BCLK = 0, LRCLK = 0, data = 0, divider = 0, k = 63, pending = 0, holding = 0, shifters = 0, all pulse outputs = 0.
REQ-025 SHALL make the first falling event after reset release occur 2*BCLK_HALF cycles later and perform a frame load with k = 0.
REQ-026 SHALL abort the current frame on reset assertion mid-frame, with all outputs at reset values in the next cycle.

Verification
REQ-027 Scenario, single frame: reset, then strobe L = 16'hA5C3, R = 16'h0F0F before the first load -> BCLK period 24 cycles; LRCLK period 1536 cycles; the bench's receiver model decodes A5C3/0F0F; frame_pulse_out fires once per 1536 cycles.
REQ-028 Scenario, I2S alignment: one BCLK after an LRCLK 1->0 edge -> data shows bit15 of left; bits in slot positions 17..31 are 0.
REQ-029 Scenario, underrun: no strobe for 2 frames after L = 16'h1234 -> 1234 is repeated; underrun_out pulses at each of the two loads.
REQ-030 Scenario, overrun: two strobes (L = 1, then L = 2) within one frame -> overrun_out pulses once; next frame carries L = 2.
REQ-031 Scenario, coincident strobe: strobe L = 16'h7FFF in the exact load cycle -> current frame carries the old pair; next frame carries 7FFF; no flags.
REQ-032 Scenario, mid-frame reset: rst_in = 0 at k = 20 for 3 cycles -> outputs at reset values; after release, frame restarts at k = 0 with an underrun pulse.

Source files
------------

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: 16-bit stereo, 64 BCLK per frame, one-BCLK data delay.
// Samples are double-buffered (holding register -> frame shifters) with under/overrun flags.
module i2s_transmitter #(
    parameter int unsigned BCLK_HALF = 12  // clk_in cycles per BCLK half-period, 2..255
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] left_sample_in,
    input  logic [15:0] right_sample_in,
    input  logic        new_sample_in,
    output logic        i2s_bclk_out,
    output logic        i2s_lrclk_out,
    output logic        i2s_data_out,
    output logic        frame_pulse_out,
    output logic        underrun_out,
    output logic        overrun_out
);

    localparam logic [7:0] DivLast = 8'(BCLK_HALF - 1);

    logic [7:0]  div_q, div_d;
    logic        bclk_q, bclk_d;
    logic [5:0]  k_q, k_d;
    logic        lrclk_q, lrclk_d;
    logic        data_q, data_d;
    logic        pending_q, pending_d;
    logic [15:0] hold_l_q, hold_l_d;
    logic [15:0] hold_r_q, hold_r_d;
    logic [15:0] shift_l_q, shift_l_d;
    logic [15:0] shift_r_q, shift_r_d;
    logic        frame_q, frame_d;
    logic        under_q, under_d;
    logic        over_q, over_d;

    logic tick;
    logic fall;
    logic load;

    // Slot bit for counter value k: one-BCLK delay puts bit 15 at slot position 1.
    function automatic logic slot_bit(input logic [5:0] k, input logic [15:0] l,
                                      input logic [15:0] r);
        logic [4:0] pos;
        logic [4:0] idx;
        pos = k[4:0];
        idx = 5'd16 - pos;
        if (pos == 5'd0 || pos > 5'd16) begin
            return 1'b0;
        end
        return k[5] ? r[idx[3:0]] : l[idx[3:0]];
    endfunction

    assign tick = (div_q == DivLast);
    assign fall = tick & bclk_q;
    assign load = fall & (k_q == 6'd63);

    always_comb begin
        div_d     = tick ? 8'd0 : div_q + 8'd1;
        bclk_d    = tick ? ~bclk_q : bclk_q;
        k_d       = k_q;
        lrclk_d   = lrclk_q;
        data_d    = data_q;
        pending_d = pending_q;
        hold_l_d  = hold_l_q;
        hold_r_d  = hold_r_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        frame_d   = 1'b0;
        under_d   = 1'b0;
        over_d    = 1'b0;

        // A strobe coinciding with a load is consumed by the next frame, so no flags.
        if (load) begin
            shift_l_d = hold_l_q;
            shift_r_d = hold_r_q;
            pending_d = new_sample_in;
            frame_d   = 1'b1;
            under_d   = ~pending_q & ~new_sample_in;
        end else if (new_sample_in) begin
            pending_d = 1'b1;
            over_d    = pending_q;
        end

        if (new_sample_in) begin
            hold_l_d = left_sample_in;
            hold_r_d = right_sample_in;
        end

        if (fall) begin
            k_d     = k_q + 6'd1;
            lrclk_d = k_d[5];
            data_d  = slot_bit(k_d, shift_l_d, shift_r_d);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            div_q     <= 8'd0;
            bclk_q    <= 1'b0;
            k_q       <= 6'd63;
            lrclk_q   <= 1'b0;
            data_q    <= 1'b0;
            pending_q <= 1'b0;
            hold_l_q  <= 16'd0;
            hold_r_q  <= 16'd0;
            shift_l_q <= 16'd0;
            shift_r_q <= 16'd0;
            frame_q   <= 1'b0;
            under_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            bclk_q    <= bclk_d;
            k_q       <= k_d;
            lrclk_q   <= lrclk_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            shift_l_q <= shift_l_d;
            shift_r_q <= shift_r_d;
            frame_q   <= frame_d;
            under_q   <= under_d;
            over_q    <= over_d;
        end
    end

    assign i2s_bclk_out    = bclk_q;
    assign i2s_lrclk_out   = lrclk_q;
    assign i2s_data_out    = data_q;
    assign frame_pulse_out = frame_q;
    assign underrun_out    = under_q;
    assign overrun_out     = over_q;

endmodule
